array_write_arbiter: RTL and testbench
======================================

Name: array_write_arbiter

Overview:
- Shares the single write port of the register-array block (index/element/enable/clear interface) among REQUESTERS clients using valid/ready handshakes and round-robin arbitration.
- Sequences array clears and keeps a per-entry "written since last clear" bitmap for downstream OR-reduction and occupancy logic.
- Sits directly in front of the array instance; all array control inputs come from registers in this block.

Parameters:
- REQUESTERS, 4, number of write clients (>=1).
- ELEMENTS, 16, array depth (>=2; need not be a power of two).
- WIDTH, 32, element width in bits.
- IW (localparam), $clog2(ELEMENTS), index width.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  [REQUESTERS-1:0]  per-client write request.
- req_ready  out  [REQUESTERS-1:0]  per-client grant; combinational, at most one bit high.
- req_index  in  [REQUESTERS-1:0][IW-1:0]  per-client target index.
- req_element  in  [REQUESTERS-1:0][WIDTH-1:0]  per-client write data.
- clear_req  in  1  level request to clear the whole array.
- clear_done  out  1  one-cycle pulse when the clear completes.
- arr_index  out  IW  to the array index input (registered).
- arr_element  out  WIDTH  to the array element input (registered).
- arr_enable  out  1  to the array enable input (registered).
- arr_clear  out  1  to the array clear input (registered).
- written  out  ELEMENTS  bit i = entry i written since the last clear.
- err_range  out  1  one-cycle pulse when an out-of-range write is dropped.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE, rr_ptr = 0, written = 0.
- FSM states and transitions:
  - IDLE: if clear_req, go to CLR_ISSUE; no req_ready this cycle.
  - CLR_ISSUE: arr_clear registered high for exactly one cycle; go to CLR_WAIT.
  - CLR_WAIT: one cycle for the array to take the clear; clear_done pulses on the exit edge; return to IDLE.
- Grant rule:
  - Only in IDLE with clear_req low.
  - Grant goes to the first asserted req_valid found searching from rr_ptr upward, wrapping modulo REQUESTERS.
  - req_ready[k] is high in the same cycle; the transfer happens when req_valid[k] and req_ready[k] are both high.
  - After a grant to k, rr_ptr <= (k+1) mod REQUESTERS.
  - With no valid requests, rr_ptr holds.
- Write timing:
  - Handshake in cycle t: arr_index, arr_element and arr_enable are registered at the end of t and are high during t+1.
  - The array updates on the edge ending t+1.
  - arr_enable is low in every cycle with no handshake.
  - Throughput: one write per cycle.
- Range check:
  - If the granted req_index >= ELEMENTS, the handshake still completes (ready high) so the client is not stuck.
  - arr_enable stays 0 and err_range pulses in t+1.
- Bitmap:
  - written[arr_index] is set on the edge where arr_enable is high.
  - written is zeroed on the edge where arr_clear is high.
  - A write issued in the same cycle as arr_clear cannot occur, because grants are blocked outside IDLE.
- Clear priority:
  - clear_req beats pending writes. Clients keep valid asserted and are served after return to IDLE, with rr_ptr unchanged.
  - clear_req still high on the return to IDLE starts another clear.
- Reset asserted mid-clear or mid-write aborts it: arr_clear and arr_enable drop immediately and written is zeroed.
- REQUESTERS == 1: rr_ptr is constant 0.

Optional Feature:
- Macro: ARRAY_ARB_PRIORITY_EN.
- Defined: requester 0 has strict priority. Whenever req_valid[0] is high in IDLE, requester 0 is granted regardless of rr_ptr, and rr_ptr is not updated by that grant. Requesters 1..R-1 round-robin among themselves.
- Not defined: pure round-robin across all requesters as described above.

Test Plan:
- Reset, then req_valid=4'b1111 held for 4 cycles, indices 0..3 -> grants in order 0,1,2,3; arr_enable high for 4 consecutive cycles one cycle later; written=16'h000F.
- rr_ptr=2 after a grant to 1, then req_valid=4'b0011 -> requester 0 is granted first (wrap-around), then 1.
- clear_req pulsed while req_valid[1] is high -> req_ready stays 0; arr_clear high one cycle; clear_done two cycles after the clear starts; written=0; requester 1 is granted on the next IDLE cycle.
- ELEMENTS=12, write to index 13 -> ready handshake completes, arr_enable=0, err_range pulses once, written unchanged.
- Reset asserted during CLR_ISSUE -> arr_clear drops asynchronously, busy=0, clear_done never pulses.
- ARRAY_ARB_PRIORITY_EN defined, req_valid=4'b0111 held 3 cycles -> requester 0 granted each cycle; with req_valid[0] dropped, 1 and 2 alternate.

Source files
------------

// File: rtl/array_write_arbiter.sv
// Round-robin write-port arbiter and clear sequencer for the register array.
// Define ARRAY_ARB_PRIORITY_EN to give requester 0 strict priority over the rest.
module array_write_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int ELEMENTS   = 16,
  parameter int WIDTH      = 32,
  localparam int IW        = $clog2(ELEMENTS)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [REQUESTERS-1:0]               req_valid,
  output logic [REQUESTERS-1:0]               req_ready,
  input  logic [REQUESTERS-1:0][IW-1:0]       req_index,
  input  logic [REQUESTERS-1:0][WIDTH-1:0]    req_element,
  input  logic                                clear_req,
  output logic                                clear_done,
  output logic [IW-1:0]                       arr_index,
  output logic [WIDTH-1:0]                    arr_element,
  output logic                                arr_enable,
  output logic                                arr_clear,
  output logic [ELEMENTS-1:0]                 written,
  output logic                                err_range,
  output logic                                busy
);

  localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam logic [IW:0] LIM = (IW+1)'(ELEMENTS);
`ifdef ARRAY_ARB_PRIORITY_EN
  localparam int SKIP = 0;
`else
  localparam int SKIP = -1;
`endif

  typedef enum logic [1:0] {
    IDLE,
    CLR_ISSUE,
    CLR_WAIT
  } state_t;

  state_t              state_q;
  logic [PW-1:0]       rr_ptr_q;
  logic [PW-1:0]       rr_ptr_d;
  logic [IW-1:0]       arr_index_q;
  logic [WIDTH-1:0]    arr_element_q;
  logic                arr_enable_q;
  logic                arr_clear_q;
  logic                clear_done_q;
  logic                err_range_q;
  logic [ELEMENTS-1:0] written_q;

  logic          grant_en;
  logic          gnt_found;
  logic [PW-1:0] gnt_idx;
  logic          rr_upd;
  logic          hs;
  logic          in_range;
  int            cand;

  // Grants only in IDLE with no clear pending and reset released.
  assign grant_en = (state_q == IDLE) && !clear_req && !reset;

  // Pick the first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rr_upd    = 1'b1;
    cand      = 0;
`ifdef ARRAY_ARB_PRIORITY_EN
    if (req_valid[0]) begin
      gnt_found = 1'b1;
      rr_upd    = 1'b0;
    end
`endif
    for (int i = 0; i < REQUESTERS; i++) begin
      cand = (int'(rr_ptr_q) + i) % REQUESTERS;
      if (!gnt_found && req_valid[cand] && cand != SKIP) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(cand);
      end
    end
  end

  // One-hot ready for the winner; handshake whenever it is asserted.
  always_comb begin
    req_ready = '0;
    if (grant_en && gnt_found)
      req_ready[gnt_idx] = 1'b1;
  end

  assign hs       = grant_en && gnt_found;
  assign in_range = {1'b0, req_index[gnt_idx]} < LIM;
  assign rr_ptr_d = (int'(gnt_idx) == REQUESTERS - 1) ? '0
                                                      : gnt_idx + 1'b1;

  // Clear FSM, registered array controls, pointer and bitmap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      arr_index_q   <= '0;
      arr_element_q <= '0;
      arr_enable_q  <= 1'b0;
      arr_clear_q   <= 1'b0;
      clear_done_q  <= 1'b0;
      err_range_q   <= 1'b0;
      written_q     <= '0;
    end else begin
      arr_enable_q <= 1'b0;
      arr_clear_q  <= 1'b0;
      clear_done_q <= 1'b0;
      err_range_q  <= 1'b0;
      if (arr_clear_q)
        written_q <= '0;
      else if (arr_enable_q)
        written_q[arr_index_q] <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_q     <= CLR_ISSUE;
            arr_clear_q <= 1'b1;
          end else if (hs) begin
            arr_index_q   <= req_index[gnt_idx];
            arr_element_q <= req_element[gnt_idx];
            arr_enable_q  <= in_range;
            err_range_q   <= !in_range;
            if (rr_upd)
              rr_ptr_q <= rr_ptr_d;
          end
        end
        CLR_ISSUE: state_q <= CLR_WAIT;
        CLR_WAIT: begin
          state_q      <= IDLE;
          clear_done_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arr_index   = arr_index_q;
  assign arr_element = arr_element_q;
  assign arr_enable  = arr_enable_q;
  assign arr_clear   = arr_clear_q;
  assign clear_done  = clear_done_q;
  assign err_range   = err_range_q;
  assign written     = written_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_array_write_arbiter.sv
// Directed vector bench for array_write_arbiter (4 clients, 12 entries).
// Covers round-robin order, range errors, clear sequencing and reset abort.
module tb_array_write_arbiter;
  localparam int R  = 4;
  localparam int E  = 12;
  localparam int W  = 32;
  localparam int IW = 4;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [R-1:0]            req_valid;
  logic [R-1:0]            req_ready;
  logic [R-1:0][IW-1:0]    req_index;
  logic [R-1:0][W-1:0]     req_element;
  logic                    clear_req;
  logic                    clear_done;
  logic [IW-1:0]           arr_index;
  logic [W-1:0]            arr_element;
  logic                    arr_enable;
  logic                    arr_clear;
  logic [E-1:0]            written;
  logic                    err_range;
  logic                    busy;

  int total = 0;
  int passed = 0;
  int done_seen = 0;
  int dn;

  always #5 clock = ~clock;

  array_write_arbiter #(
    .REQUESTERS(R),
    .ELEMENTS  (E),
    .WIDTH     (W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_index  (req_index),
    .req_element(req_element),
    .clear_req  (clear_req),
    .clear_done (clear_done),
    .arr_index  (arr_index),
    .arr_element(arr_element),
    .arr_enable (arr_enable),
    .arr_clear  (arr_clear),
    .written    (written),
    .err_range  (err_range),
    .busy       (busy)
  );

  always @(negedge clock)
    if (clear_done) done_seen++;

  typedef struct {
    logic [3:0]  vld;
    logic [15:0] ix;
    logic [3:0]  rdy;
    logic        en;
    logic [3:0]  ai;
    logic        err;
    logic [11:0] wr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] v, input logic [15:0] ix,
                              input logic [3:0] rdy, input logic en,
                              input logic [3:0] ai, input logic err,
                              input logic [11:0] wr);
    vec_t t;
    t.vld = v; t.ix = ix; t.rdy = rdy; t.en = en;
    t.ai = ai; t.err = err; t.wr = wr;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  initial begin
    logic [31:0] ee;
`ifdef ARRAY_ARB_PRIORITY_EN
    tbl.push_back(mk(4'b0111, 16'h3210, 4'b0001, 1, 0, 0, 12'h000));
    tbl.push_back(mk(4'b0111, 16'h3210, 4'b0001, 1, 0, 0, 12'h001));
    tbl.push_back(mk(4'b0111, 16'h3210, 4'b0001, 1, 0, 0, 12'h001));
    tbl.push_back(mk(4'b0110, 16'h3210, 4'b0010, 1, 1, 0, 12'h001));
    tbl.push_back(mk(4'b0110, 16'h3210, 4'b0100, 1, 2, 0, 12'h003));
    tbl.push_back(mk(4'b0110, 16'h3210, 4'b0010, 1, 1, 0, 12'h007));
    tbl.push_back(mk(4'b0000, 16'h3210, 4'b0000, 0, 0, 0, 12'h007));
`else
    tbl.push_back(mk(4'b1111, 16'h3210, 4'b0001, 1, 0, 0, 12'h000));
    tbl.push_back(mk(4'b1111, 16'h3210, 4'b0010, 1, 1, 0, 12'h001));
    tbl.push_back(mk(4'b1111, 16'h3210, 4'b0100, 1, 2, 0, 12'h003));
    tbl.push_back(mk(4'b1111, 16'h3210, 4'b1000, 1, 3, 0, 12'h007));
    tbl.push_back(mk(4'b0000, 16'h3210, 4'b0000, 0, 0, 0, 12'h00F));
    tbl.push_back(mk(4'b0010, 16'h3210, 4'b0010, 1, 1, 0, 12'h00F));
    tbl.push_back(mk(4'b0011, 16'h3210, 4'b0001, 1, 0, 0, 12'h00F));
    tbl.push_back(mk(4'b0011, 16'h3210, 4'b0010, 1, 1, 0, 12'h00F));
    tbl.push_back(mk(4'b0000, 16'h3210, 4'b0000, 0, 0, 0, 12'h00F));
    tbl.push_back(mk(4'b0100, 16'h3D10, 4'b0100, 0, 0, 1, 12'h00F));
    tbl.push_back(mk(4'b0000, 16'h3D10, 4'b0000, 0, 0, 0, 12'h00F));
    tbl.push_back(mk(4'b1000, 16'hB210, 4'b1000, 1, 11, 0, 12'h00F));
    tbl.push_back(mk(4'b0000, 16'hB210, 4'b0000, 0, 0, 0, 12'h80F));
`endif

    for (int k = 0; k < R; k++) req_element[k] = 32'hA0 + k;
    reset = 1'b1;
    clear_req = 1'b0;
    req_valid = 4'b1111;
    req_index = 16'h3210;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst ready", req_ready, 0);
    chk("rst enable", arr_enable, 0);
    chk("rst clear", arr_clear, 0);
    chk("rst done", clear_done, 0);
    chk("rst err", err_range, 0);
    chk("rst busy", busy, 0);
    chk("rst written", written, 0);
    chk("rst index", arr_index, 0);
    chk("rst element", arr_element, 0);
    reset = 1'b0;
    req_valid = '0;

    foreach (tbl[n]) begin
      @(negedge clock);
      req_valid = tbl[n].vld;
      req_index = tbl[n].ix;
      #1 chk($sformatf("v%0d ready", n), req_ready, tbl[n].rdy);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d enable", n), arr_enable, tbl[n].en);
      chk($sformatf("v%0d err", n), err_range, tbl[n].err);
      chk($sformatf("v%0d written", n), written, tbl[n].wr);
      if (tbl[n].en) begin
        ee = 0;
        for (int k = 0; k < R; k++)
          if (tbl[n].rdy[k]) ee = 32'hA0 + k;
        chk($sformatf("v%0d index", n), arr_index, tbl[n].ai);
        chk($sformatf("v%0d element", n), arr_element, ee);
      end
    end

    // clear with a pending request from client 1
    @(negedge clock);
    clear_req = 1'b1;
    req_valid = 4'b0010;
    req_index = 16'h3250;
    #1 chk("clr ready0", req_ready, 0);
    @(posedge clock); #1;
    chk("clr issue", arr_clear, 1);
    chk("clr busy", busy, 1);
    @(negedge clock);
    clear_req = 1'b0;
    #1 chk("clr ready1", req_ready, 0);
    @(posedge clock); #1;
    chk("clr drop", arr_clear, 0);
    chk("clr written", written, 0);
    chk("clr done early", clear_done, 0);
    @(posedge clock); #1;
    chk("clr done", clear_done, 1);
    chk("clr idle", busy, 0);
    chk("clr regrant", req_ready, 4'b0010);
    @(posedge clock); #1;
    chk("clr done pulse", clear_done, 0);
    chk("clr wr enable", arr_enable, 1);
    chk("clr wr index", arr_index, 5);
    chk("clr wr element", arr_element, 32'hA1);
    @(negedge clock);
    req_valid = '0;
    @(posedge clock); #1;
    chk("clr bitmap", written, 12'h020);

    // reset during CLR_ISSUE
    @(negedge clock);
    clear_req = 1'b1;
    @(posedge clock); #1;
    chk("abort issue", arr_clear, 1);
    dn = done_seen;
    #2 reset = 1'b1;
    #1;
    chk("abort clear", arr_clear, 0);
    chk("abort busy", busy, 0);
    chk("abort written", written, 0);
    clear_req = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("abort no done", done_seen, dn);
    chk("abort still idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
